// File: rtl/ahb_lite_mst.sv
// ---------------------------------------------------------------------------
// ahb_lite_mst
//   Single-outstanding AHB-Lite master. A simple valid/ready command port is
//   turned into one SINGLE transfer (IDLE -> ADDR -> DATA). The result comes
//   back as a one-cycle rsp_valid strobe with read data and error flags.
//   Misaligned or oversized commands are rejected locally with no bus traffic.
//
// Optional feature (macro AHB_MST_TIMEOUT_EN):
//   A 4-bit counter counts consecutive hready_resp=0 cycles in ADDR/DATA. On
//   the 16th such cycle the transfer is abandoned with rsp_err=rsp_timeout=1.
//   Without the macro the master waits indefinitely and rsp_timeout is 0.
//
// Ports:
//   hclk, hreset        clock (rising edge), synchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while IDLE
//   cmd_write/addr/size/wdata  command fields (size uses AHB hsize encoding)
//   rsp_valid           one-cycle response strobe (no backpressure)
//   rsp_rdata/err/timeout  response payload
//   hsel/haddr/htrans/hsize/hburst/hwrite/hwdata  AHB master outputs
//   hready              hready_resp forwarded to the slave
//   hready_resp/hresp/hrdata  AHB slave responses
// ---------------------------------------------------------------------------
module ahb_lite_mst #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    output logic              hready,
    input  logic              hready_resp,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t            state_r,       state_s;
    logic              cmd_ready_r,   cmd_ready_s;
    logic              hsel_r,        hsel_s;
    logic [ADDR_W-1:0] haddr_r,       haddr_s;
    logic [1:0]        htrans_r,      htrans_s;
    logic [2:0]        hsize_r,       hsize_s;
    logic              hwrite_r,      hwrite_s;
    logic [DATA_W-1:0] hwdata_r,      hwdata_s;
    logic              rsp_valid_r,   rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_r,   rsp_rdata_s;
    logic              rsp_err_r,     rsp_err_s;
    logic              rsp_timeout_r, rsp_timeout_s;
    logic              handshake_s;
    logic              unused_s;

`ifdef AHB_MST_TIMEOUT_EN
    logic [3:0]        tmo_cnt_r,     tmo_cnt_s;
`endif

    // True when addr is aligned to 2^size bytes and size is at most a word.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (addr_lsb[0] == 1'b0);
            3'd2:    ok = (addr_lsb == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign handshake_s = cmd_valid & cmd_ready_r;

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_s       = state_r;
        hsel_s        = hsel_r;
        haddr_s       = haddr_r;
        htrans_s      = htrans_r;
        hsize_s       = hsize_r;
        hwrite_s      = hwrite_r;
        hwdata_s      = hwdata_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_err_s     = rsp_err_r;
        rsp_timeout_s = rsp_timeout_r;
`ifdef AHB_MST_TIMEOUT_EN
        tmo_cnt_s     = tmo_cnt_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
                        state_s  = ST_ADDR;
                        hsel_s   = 1'b1;
                        htrans_s = HTRANS_NONSEQ;
                        haddr_s  = cmd_addr;
                        hsize_s  = cmd_size;
                        hwrite_s = cmd_write;
                        // Write data is captured now and held through DATA.
                        hwdata_s = cmd_wdata;
                    end else begin
                        // Rejected locally: immediate error, no bus transfer.
                        rsp_valid_s   = 1'b1;
                        rsp_err_s     = 1'b1;
                        rsp_timeout_s = 1'b0;
                        rsp_rdata_s   = {DATA_W{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                if (hready_resp) begin
                    state_s  = ST_DATA;
                    hsel_s   = 1'b0;
                    htrans_s = HTRANS_IDLE;
                end else begin
`ifdef AHB_MST_TIMEOUT_EN
                    if (tmo_cnt_r == 4'd15) begin
                        state_s       = ST_IDLE;
                        hsel_s        = 1'b0;
                        htrans_s      = HTRANS_IDLE;
                        rsp_valid_s   = 1'b1;
                        rsp_err_s     = 1'b1;
                        rsp_timeout_s = 1'b1;
                        rsp_rdata_s   = {DATA_W{1'b0}};
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + 4'd1;
                    end
`else
                    state_s = ST_ADDR;
`endif
                end
            end

            ST_DATA: begin
                // An ERROR first cycle arrives with hready_resp=0 and is just a wait.
                if (hready_resp) begin
                    state_s       = ST_IDLE;
                    rsp_valid_s   = 1'b1;
                    rsp_err_s     = hresp[0];
                    rsp_timeout_s = 1'b0;
                    if (!hwrite_r && !hresp[0]) begin
                        rsp_rdata_s = hrdata;
                    end else begin
                        rsp_rdata_s = {DATA_W{1'b0}};
                    end
                end else begin
`ifdef AHB_MST_TIMEOUT_EN
                    if (tmo_cnt_r == 4'd15) begin
                        state_s       = ST_IDLE;
                        rsp_valid_s   = 1'b1;
                        rsp_err_s     = 1'b1;
                        rsp_timeout_s = 1'b1;
                        rsp_rdata_s   = {DATA_W{1'b0}};
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + 4'd1;
                    end
`else
                    state_s = ST_DATA;
`endif
                end
            end

            default: begin
                state_s  = ST_IDLE;
                hsel_s   = 1'b0;
                htrans_s = HTRANS_IDLE;
            end
        endcase

`ifdef AHB_MST_TIMEOUT_EN
        // Counter restarts on every state change and is idle outside a transfer.
        if ((state_s != state_r) || (state_r == ST_IDLE)) begin
            tmo_cnt_s = 4'd0;
        end else begin
            tmo_cnt_s = tmo_cnt_s;
        end
`endif

        // Registered ready: low in reset, high from the first edge after release.
        cmd_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r       <= ST_IDLE;
            cmd_ready_r   <= 1'b0;
            hsel_r        <= 1'b0;
            haddr_r       <= {ADDR_W{1'b0}};
            htrans_r      <= HTRANS_IDLE;
            hsize_r       <= 3'd0;
            hwrite_r      <= 1'b0;
            hwdata_r      <= {DATA_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cmd_ready_r   <= cmd_ready_s;
            hsel_r        <= hsel_s;
            haddr_r       <= haddr_s;
            htrans_r      <= htrans_s;
            hsize_r       <= hsize_s;
            hwrite_r      <= hwrite_s;
            hwdata_r      <= hwdata_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_err_r     <= rsp_err_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

`ifdef AHB_MST_TIMEOUT_EN
    // Consecutive wait-cycle counter.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            tmo_cnt_r <= 4'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end
    assign rsp_timeout = rsp_timeout_r;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = cmd_ready_r;
    assign hsel      = hsel_r;
    assign haddr     = haddr_r;
    assign htrans    = htrans_r;
    assign hsize     = hsize_r;
    assign hburst    = 3'b000;
    assign hwrite    = hwrite_r;
    assign hwdata    = hwdata_r;
    assign hready    = hready_resp;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Only OKAY/ERROR are used; hresp[1] and rsp_timeout_r (timeout disabled) are unread.
    assign unused_s = ^{hresp[1], rsp_timeout_r};

endmodule
